fpu_result_collector: RTL and testbench

- Downstream stage of the fp_add and fp_comp units. It captures each completed result on the rising edge of that unit's done signal.
- Each result is tagged by source and pushed into a small first-word-fall-through (show-ahead) FIFO.
- IEEE exception flags are accumulated as sticky status, and an interrupt is raised for the management SoC.
- fpu_interconnect drains the FIFO through its Wishbone register map.

---
 rtl/fpu_pkg.sv | 60 ++++++
 rtl/fpu_sync_fifo.sv | 52 +++++
 rtl/fpu_result_collector.sv | 167 ++++++++++++++++
 tb/tb_fpu_result_collector.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU result collector.
// FPU_RESULT_TIMESTAMP_EN adds a 16-bit cycle stamp to each entry.
package fpu_pkg;

  localparam logic TAG_ADD = 1'b0;
  localparam logic TAG_CMP = 1'b1;

  localparam int FLG_INV = 3;
  localparam int FLG_OV  = 2;
  localparam int FLG_UN  = 1;
  localparam int FLG_NX  = 0;

  localparam int CMP_EQ    = 0;
  localparam int CMP_LESS  = 1;
  localparam int CMP_GREAT = 2;

`ifdef FPU_RESULT_TIMESTAMP_EN
  localparam int ENTRY_W = 32 + 1 + 4 + 16;
`else
  localparam int ENTRY_W = 32 + 1 + 4;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        tag;
    logic [3:0]  flags;
`ifdef FPU_RESULT_TIMESTAMP_EN
    logic [15:0] stamp;
`endif
  } entry_t;

  function automatic logic [3:0] pack_flags(
    input logic inv,
    input logic ov,
    input logic un,
    input logic nx
  );
    logic [3:0] f;
    f = '0;
    f[FLG_INV] = inv;
    f[FLG_OV]  = ov;
    f[FLG_UN]  = un;
    f[FLG_NX]  = nx;
    return f;
  endfunction

  function automatic logic [31:0] pack_cmp(
    input logic eq,
    input logic less,
    input logic great
  );
    logic [31:0] d;
    d = '0;
    d[CMP_EQ]    = eq;
    d[CMP_LESS]  = less;
    d[CMP_GREAT] = great;
    return d;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Generic show-ahead synchronous FIFO; head word is visible on rdata.
// Push while full succeeds only together with a pop; pop while empty is ignored.
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_nxt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fpu_result_collector.sv
// Captures fp_add / fp_comp results into a tagged FIFO with sticky flags and irq.
// FPU_RESULT_TIMESTAMP_EN stores a free-running cycle stamp per entry.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int IRQ_LEVEL = 1
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         add_done,
  input  logic [31:0]                  add_out,
  input  logic                         add_ov,
  input  logic                         add_un,
  input  logic                         add_inv,
  input  logic                         add_inexact,
  input  logic                         cmp_done,
  input  logic                         cmp_eq,
  input  logic                         cmp_less,
  input  logic                         cmp_great,
  input  logic                         cmp_inv,
  input  logic                         rd_en,
  output logic [31:0]                  rd_data,
  output logic                         rd_tag,
  output logic [3:0]                   rd_flags,
  output logic [15:0]                  rd_stamp,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [3:0]                   sticky_flags,
  input  logic                         flags_clr,
  output logic                         overflow_err,
  output logic                         irq
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] IRQ_LVL = CW'(IRQ_LEVEL);

  logic         add_done_q;
  logic         cmp_done_q;
  logic         add_evt;
  logic         cmp_evt;
  entry_t       add_ent;
  entry_t       cmp_ent;
  entry_t       wr_ent;
  entry_t       pend_ent;
  entry_t       head_ent;
  logic         pend_vld;
  logic         pend_load;
  logic         push_req;
  logic         drop;
  logic [3:0]   evt_flags;
  logic [3:0]   sticky_nxt;
  logic         ovf_nxt;
  logic [CW-1:0] count_nxt;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign add_evt = add_done & ~add_done_q;
  assign cmp_evt = cmp_done & ~cmp_done_q;

`ifdef FPU_RESULT_TIMESTAMP_EN
  logic [15:0] stamp_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) stamp_q <= '0;
    else          stamp_q <= stamp_q + 16'd1;
  end
`endif

  always_comb begin
    add_ent       = '0;
    add_ent.data  = add_out;
    add_ent.tag   = TAG_ADD;
    add_ent.flags = pack_flags(add_inv, add_ov, add_un, add_inexact);
    cmp_ent       = '0;
    cmp_ent.data  = pack_cmp(cmp_eq, cmp_less, cmp_great);
    cmp_ent.tag   = TAG_CMP;
    cmp_ent.flags = pack_flags(cmp_inv, 1'b0, 1'b0, 1'b0);
`ifdef FPU_RESULT_TIMESTAMP_EN
    add_ent.stamp = stamp_q;
    cmp_ent.stamp = stamp_q;
`endif
  end

  // add wins the single write port; a colliding cmp waits one cycle
  always_comb begin
    push_req  = 1'b0;
    pend_load = 1'b0;
    wr_ent    = add_ent;
    unique case (1'b1)
      add_evt: begin
        push_req  = 1'b1;
        pend_load = cmp_evt;
      end
      !add_evt && pend_vld: begin
        push_req  = 1'b1;
        wr_ent    = pend_ent;
        pend_load = cmp_evt;
      end
      !add_evt && !pend_vld && cmp_evt: begin
        push_req = 1'b1;
        wr_ent   = cmp_ent;
      end
      default: ;
    endcase
  end

  assign drop = push_req & full & ~rd_en;

  assign evt_flags = (add_evt ? add_ent.flags : 4'b0000)
                   | (cmp_evt ? cmp_ent.flags : 4'b0000);

  assign sticky_nxt = (flags_clr ? 4'b0000 : sticky_flags) | evt_flags;
  assign ovf_nxt    = (flags_clr ? 1'b0 : overflow_err) | drop;

  fpu_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push     (push_req),
    .wdata    (wr_ent),
    .pop      (rd_en),
    .rdata    (fifo_rdata),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .count_nxt(count_nxt)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      add_done_q   <= 1'b1;
      cmp_done_q   <= 1'b1;
      pend_vld     <= 1'b0;
      pend_ent     <= '0;
      sticky_flags <= '0;
      overflow_err <= 1'b0;
      irq          <= 1'b0;
    end else begin
      add_done_q   <= add_done;
      cmp_done_q   <= cmp_done;
      if (pend_load) begin
        pend_vld <= 1'b1;
        pend_ent <= cmp_ent;
      end else if (!add_evt) begin
        pend_vld <= 1'b0;
      end
      sticky_flags <= sticky_nxt;
      overflow_err <= ovf_nxt;
      irq          <= (count_nxt >= IRQ_LVL) | ovf_nxt;
    end
  end

  assign head_ent = fifo_rdata;

  assign rd_data  = empty ? 32'h0 : head_ent.data;
  assign rd_tag   = empty ? 1'b0  : head_ent.tag;
  assign rd_flags = empty ? 4'h0  : head_ent.flags;
`ifdef FPU_RESULT_TIMESTAMP_EN
  assign rd_stamp = empty ? 16'h0 : head_ent.stamp;
`else
  assign rd_stamp = 16'h0000;
`endif

endmodule

// File: tb/tb_fpu_result_collector.sv
// Bench for fpu_result_collector: directed table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_fpu_result_collector;

  localparam int DEPTH     = 8;
  localparam int IRQ_LEVEL = 1;
  localparam int CW        = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          add_done;
  logic [31:0]   add_out;
  logic [3:0]    add_fl;
  logic          cmp_done, cmp_eq, cmp_less, cmp_great, cmp_inv;
  logic          rd_en, clr;
  logic [31:0]   rd_data;
  logic          rd_tag;
  logic [3:0]    rd_flags;
  logic [15:0]   rd_stamp;
  logic          empty, full;
  logic [CW-1:0] count;
  logic [3:0]    sticky_flags;
  logic          overflow_err, irq;

  always #5 clk = ~clk;

  fpu_result_collector #(
    .DEPTH(DEPTH),
    .IRQ_LEVEL(IRQ_LEVEL)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .add_done    (add_done),
    .add_out     (add_out),
    .add_ov      (add_fl[2]),
    .add_un      (add_fl[1]),
    .add_inv     (add_fl[3]),
    .add_inexact (add_fl[0]),
    .cmp_done    (cmp_done),
    .cmp_eq      (cmp_eq),
    .cmp_less    (cmp_less),
    .cmp_great   (cmp_great),
    .cmp_inv     (cmp_inv),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_tag      (rd_tag),
    .rd_flags    (rd_flags),
    .rd_stamp    (rd_stamp),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .sticky_flags(sticky_flags),
    .flags_clr   (clr),
    .overflow_err(overflow_err),
    .irq         (irq)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        tag;
    logic [3:0]  flags;
    logic [15:0] stamp;
  } m_ent_t;

  m_ent_t      mq[$];
  m_ent_t      mpend[$];
  logic        m_add_q, m_cmp_q, m_ovf, m_irq;
  logic [3:0]  m_sticky;
  logic [15:0] m_cyc;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_ent_t a, c, w;
    logic ae, ce, have, pop, drop;
    logic [3:0] newf;
    if (rst) begin
      mq.delete();
      mpend.delete();
      m_add_q  = 1'b1;
      m_cmp_q  = 1'b1;
      m_sticky = '0;
      m_ovf    = 1'b0;
      m_irq    = 1'b0;
      m_cyc    = '0;
      return;
    end
    ae = add_done && !m_add_q;
    ce = cmp_done && !m_cmp_q;
    a.data  = add_out;
    a.tag   = 1'b0;
    a.flags = add_fl;
    c.data  = {29'b0, cmp_great, cmp_less, cmp_eq};
    c.tag   = 1'b1;
    c.flags = {cmp_inv, 3'b000};
`ifdef FPU_RESULT_TIMESTAMP_EN
    a.stamp = m_cyc;
    c.stamp = m_cyc;
`else
    a.stamp = 16'h0;
    c.stamp = 16'h0;
`endif
    newf = (ae ? a.flags : 4'h0) | (ce ? c.flags : 4'h0);
    have = 1'b0;
    w    = a;
    if (ae) begin
      have = 1'b1;
      if (ce) mpend.push_back(c);
    end else if (mpend.size() > 0) begin
      w    = mpend.pop_front();
      have = 1'b1;
      if (ce) mpend.push_back(c);
    end else if (ce) begin
      w    = c;
      have = 1'b1;
    end
    pop  = rd_en && (mq.size() > 0);
    drop = have && (mq.size() == DEPTH) && !rd_en;
    if (pop) void'(mq.pop_front());
    if (have && !drop) mq.push_back(w);
    m_sticky = (clr ? 4'h0 : m_sticky) | newf;
    m_ovf    = (clr ? 1'b0 : m_ovf) | drop;
    m_irq    = (mq.size() >= IRQ_LEVEL) || m_ovf;
    m_add_q  = add_done;
    m_cmp_q  = cmp_done;
    m_cyc    = m_cyc + 16'd1;
  endtask

  task automatic check_model();
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_sticky", 32'(sticky_flags), 32'(m_sticky));
    chk("m_ovf", 32'(overflow_err), 32'(m_ovf));
    chk("m_irq", 32'(irq), 32'(m_irq));
    if (mq.size() > 0) begin
      chk("m_data", rd_data, mq[0].data);
      chk("m_tag", 32'(rd_tag), 32'(mq[0].tag));
      chk("m_flags", 32'(rd_flags), 32'(mq[0].flags));
      chk("m_stamp", 32'(rd_stamp), 32'(mq[0].stamp));
    end
`ifndef FPU_RESULT_TIMESTAMP_EN
    chk("stamp_zero", 32'(rd_stamp), 32'h0);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    rst = 0; add_done = 0; add_out = 0; add_fl = 0;
    cmp_done = 0; cmp_eq = 0; cmp_less = 0; cmp_great = 0; cmp_inv = 0;
    rd_en = 0; clr = 0;
  endtask

  task automatic add_pulse(input logic [31:0] d);
    add_done = 1; add_out = d;
    cyc();
    add_done = 0;
    cyc();
  endtask

  typedef struct {
    logic rst, ad;
    logic [31:0] aout;
    logic [3:0] afl;
    logic cd, ceq, cls, cgt, cinv, rd, clr;
    logic e_empty;
    int e_count;
    logic [31:0] e_data;
    logic e_tag;
    logic [3:0] e_flags, e_sticky;
    logic e_irq;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1,0,32'h0,4'h0,0,0,0,0,0,0,0, 1,0,32'h0,0,4'h0,4'h0,0};
    tbl[1]  = '{1,0,32'h0,4'h0,0,0,0,0,0,0,0, 1,0,32'h0,0,4'h0,4'h0,0};
    tbl[2]  = '{0,1,32'h0,4'h0,0,0,0,0,0,0,0, 1,0,32'h0,0,4'h0,4'h0,0};
    tbl[3]  = '{0,1,32'h0,4'h0,0,0,0,0,0,0,0, 1,0,32'h0,0,4'h0,4'h0,0};
    tbl[4]  = '{0,0,32'h0,4'h0,0,0,0,0,0,0,0, 1,0,32'h0,0,4'h0,4'h0,0};
    tbl[5]  = '{0,1,32'h3FC00000,4'h1,0,0,0,0,0,0,0,
                0,1,32'h3FC00000,0,4'h1,4'h1,1};
    tbl[6]  = '{0,0,32'h0,4'h0,0,0,0,0,0,1,0, 1,0,32'h0,0,4'h0,4'h1,0};
    tbl[7]  = '{0,1,32'h40000000,4'h0,1,0,1,0,0,0,0,
                0,1,32'h40000000,0,4'h0,4'h1,1};
    tbl[8]  = '{0,0,32'h0,4'h0,0,0,0,0,0,0,0,
                0,2,32'h40000000,0,4'h0,4'h1,1};
    tbl[9]  = '{0,0,32'h0,4'h0,0,0,0,0,0,1,0, 0,1,32'h2,1,4'h0,4'h1,1};
    tbl[10] = '{0,0,32'h0,4'h0,0,0,0,0,0,1,0, 1,0,32'h0,0,4'h0,4'h1,0};
    tbl[11] = '{0,0,32'h0,4'h0,1,1,0,0,1,0,1, 0,1,32'h1,1,4'h8,4'h8,1};
    tbl[12] = '{0,0,32'h0,4'h0,0,0,0,0,0,1,0, 1,0,32'h0,0,4'h0,4'h8,0};

    idle();
    rst = 1;

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; add_done = tbl[i].ad; add_out = tbl[i].aout;
      add_fl = tbl[i].afl; cmp_done = tbl[i].cd; cmp_eq = tbl[i].ceq;
      cmp_less = tbl[i].cls; cmp_great = tbl[i].cgt; cmp_inv = tbl[i].cinv;
      rd_en = tbl[i].rd; clr = tbl[i].clr;
      cyc();
      chk($sformatf("t%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("t%0d_sticky", i), 32'(sticky_flags), 32'(tbl[i].e_sticky));
      chk($sformatf("t%0d_irq", i), 32'(irq), 32'(tbl[i].e_irq));
      if (!tbl[i].e_empty) begin
        chk($sformatf("t%0d_data", i), rd_data, tbl[i].e_data);
        chk($sformatf("t%0d_tag", i), 32'(rd_tag), 32'(tbl[i].e_tag));
        chk($sformatf("t%0d_flags", i), 32'(rd_flags), 32'(tbl[i].e_flags));
      end
      if (i == 0) begin
        chk("rst_data", rd_data, 32'h0);
        chk("rst_stamp", 32'(rd_stamp), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ovf", 32'(overflow_err), 32'h0);
      end
    end
    idle();

    // overflow: fill, drop one, drain in order
    for (int i = 0; i < DEPTH; i++) add_pulse(32'(100 + i));
    chk("fill_count", 32'(count), 32'(DEPTH));
    chk("fill_full", 32'(full), 32'h1);
    add_done = 1; add_out = 32'd999;
    cyc();
    chk("ovf_set", 32'(overflow_err), 32'h1);
    chk("ovf_irq", 32'(irq), 32'h1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    add_done = 0;
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), rd_data, 32'(100 + i));
      rd_en = 1;
      cyc();
      rd_en = 0;
    end
    chk("drain_empty", 32'(empty), 32'h1);
    chk("ovf_sticky", 32'(overflow_err), 32'h1);
    chk("ovf_irq_hold", 32'(irq), 32'h1);
    clr = 1;
    cyc();
    clr = 0;
    chk("ovf_clr", 32'(overflow_err), 32'h0);
    chk("irq_clr", 32'(irq), 32'h0);

    // full with simultaneous write and pop
    for (int i = 0; i < DEPTH; i++) add_pulse(32'(200 + i));
    add_done = 1; add_out = 32'd777; rd_en = 1;
    cyc();
    add_done = 0; rd_en = 0;
    chk("fp_count", 32'(count), 32'(DEPTH));
    chk("fp_ovf", 32'(overflow_err), 32'h0);
    chk("fp_head", rd_data, 32'd201);
    cyc();
    rd_en = 1;
    for (int i = 0; i < DEPTH - 1; i++) cyc();
    rd_en = 0;
    chk("fp_tail", rd_data, 32'd777);
    chk("fp_last", 32'(count), 32'h1);
    rd_en = 1;
    cyc();
    rd_en = 0;

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 399) == 0);
      add_done  = 1'($urandom_range(0, 1));
      add_out   = $urandom;
      add_fl    = 4'($urandom);
      cmp_done  = 1'($urandom_range(0, 1));
      cmp_eq    = 1'($urandom);
      cmp_less  = 1'($urandom);
      cmp_great = 1'($urandom);
      cmp_inv   = 1'($urandom);
      clr       = ($urandom_range(0, 19) == 0);
      if (n < 2000) rd_en = ($urandom_range(0, 3) == 0);
      else          rd_en = ($urandom_range(0, 9) < 6);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
